// File: rtl/uart_pkg.sv
// Shared types and sample-point arithmetic for the 8N1 UART receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_IDX  = UART_DATA_BITS + 1;
    localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    // Counter value (cycles since the start edge) at the centre of bit n,
    // where n=0 is the start bit and n=UART_STOP_IDX is the stop bit.
    function automatic logic [31:0] sample_pt(input logic [31:0] n, input logic [31:0] half);
        return (32'd2 * n + 32'd1) * half - 32'd1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rxd pin, preset to the idle-high level,
// plus one edge-detect flop producing a falling-edge strobe.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rxd;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, pulses rx_ready on a good byte
// and ferr on a low stop bit. UART_RX_MAJORITY_EN enables 2-of-3 sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    output logic       rx_busy
);

    logic sync, fall, samp;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .sync (sync),
        .fall (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[1] holds the line at P-1, hist_q[0] at P; the decision is made at P+1.
    localparam logic [31:0] DECIDE_DLY = 32'd1;
    logic [1:0] hist_q, hist_d;

    always_comb hist_d = {hist_q[0], sync};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end

    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync) | (hist_q[0] & sync);
`else
    localparam logic [31:0] DECIDE_DLY = 32'd0;
    assign samp = sync;
`endif

    rx_state_e                 state_q, state_d;
    logic [31:0]               cnt_q, cnt_d;
    logic [UART_BIT_IDX_W-1:0] bit_q, bit_d;
    logic [7:0]                buf_q, buf_d;
    logic [7:0]                rdata_q, rdata_d;
    logic                      rdy_q, rdy_d;
    logic                      ferr_q, ferr_d;
    logic [31:0]               n_sel;
    logic [31:0]               target;
    logic                      hit;

    always_comb begin
        case (state_q)
            START:   n_sel = 32'd0;
            DATA:    n_sel = 32'(bit_q) + 32'd1;
            default: n_sel = 32'(UART_STOP_IDX);
        endcase
        target = sample_pt(n_sel, 32'(CLK_PER_HALF_BIT)) + DECIDE_DLY;
        hit    = (cnt_q == target);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        bit_d   = bit_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Counter reads "cycles since the start edge", so it is 1 the cycle after.
                cnt_d = fall ? 32'd1 : 32'd0;
                if (fall) state_d = START;
            end
            START: begin
                if (hit) begin
                    bit_d   = '0;
                    state_d = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (hit) begin
                    buf_d = {samp, buf_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == UART_BIT_IDX_W'(UART_DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (hit) begin
                    if (samp) begin
                        rdata_d = buf_q;
                        rdy_d   = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rdata    = rdata_q;
    assign rx_ready = rdy_q;
    assign ferr     = ferr_q;
    assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLK_PER_HALF_BIT=4 (8-cycle bit period).
module tb_uart_rx;

    localparam int H   = 4;
    localparam int BIT = 2 * H;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Pin drive to pulse: 2 synchroniser cycles, then 19 half-bits from the edge.
    localparam int LAT = 19 * H + 2 + MAJ;

    typedef struct {
        logic       ok;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rdata;
    logic       rx_ready, ferr, rx_busy;

    exp_t       sbq[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_rdy = 1'b0, prev_ferr = 1'b0;

    uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_ready (rx_ready),
        .ferr     (ferr),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ready || ferr) begin
                exp_t e;
                n_total++;
                if (rx_ready && ferr) $display("FAIL both_pulses: rx_ready=1 ferr=1, want exclusive");
                else if (prev_rdy || prev_ferr) $display("FAIL pulse_width: pulse held for 2 cycles, want 1");
                else n_pass++;
                n_total++;
                if (sbq.size() == 0) begin
                    $display("FAIL unexpected_pulse: rx_ready=%0b ferr=%0b at cycle %0d, want none", rx_ready, ferr, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (rx_ready !== e.ok) $display("FAIL pulse_kind: rx_ready=%0b ferr=%0b, want rx_ready=%0b", rx_ready, ferr, e.ok);
                    else n_pass++;
                    n_total++;
                    if (rdata !== e.data) $display("FAIL rdata: got %h want %h", rdata, e.data);
                    else n_pass++;
                    n_total++;
                    if (cyc !== e.cyc) $display("FAIL latency: pulse at cycle %0d want %0d", cyc, e.cyc);
                    else n_pass++;
                end
            end
            prev_rdy  <= rx_ready;
            prev_ferr <= ferr;
        end else begin
            prev_rdy  <= 1'b0;
            prev_ferr <= 1'b0;
        end
    end

    // Inputs always change #1 after a rising edge.
    task automatic drive_cycle(input logic v);
        rxd = v;
        @(posedge clk);
        #1;
    endtask

    // glitch inverts the line for one cycle at the centre of every data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
        exp_t       e;
        logic [9:0] bits;
        bits   = {stop, d, 1'b0};
        e.ok   = stop;
        e.cyc  = cyc + LAT;
        if (stop) begin
            e.data    = (glitch && MAJ == 0) ? ~d : d;
            last_good = e.data;
        end else begin
            e.data = last_good;
        end
        sbq.push_back(e);
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < BIT; k++)
                drive_cycle((glitch && b >= 1 && b <= 8 && k == 3) ? ~bits[b] : bits[b]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            drive_cycle(rxd);
            n++;
        end
        n_total++;
        if (sbq.size() != 0) $display("FAIL %s_drain: %0d pulses outstanding, want 0", name, sbq.size());
        else n_pass++;
        repeat (4) drive_cycle(1'b1);
    endtask

    task automatic test_reset;
        #1;
        n_total++;
        if ({rdata, rx_ready, ferr, rx_busy} !== 11'h000)
            $display("FAIL reset_outputs: got rdata=%h rdy=%0b ferr=%0b busy=%0b want 0", rdata, rx_ready, ferr, rx_busy);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) drive_cycle(1'b1);
    endtask

    task automatic test_single;
        send_frame(8'h55, 1'b1, 1'b0);
        drain("single");
    endtask

    task automatic test_back_to_back;
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_framing;
        int busy = 0;
        send_frame(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0);
            if (rx_busy) busy++;
        end
        n_total++;
        if (busy != 0) $display("FAIL held_low_busy: busy for %0d cycles, want 0", busy);
        else n_pass++;
        drain("framing");
        send_frame(8'h81, 1'b1, 1'b0);
        drain("after_low");
    endtask

    task automatic test_false_start;
        int busy = 0;
        for (int i = 0; i < 22; i++) begin
            drive_cycle(i < 2 ? 1'b0 : 1'b1);
            if (rx_busy) busy++;
        end
        n_total++;
        if (busy != 3 + MAJ) $display("FAIL false_start_busy: busy %0d cycles want %0d", busy, 3 + MAJ);
        else n_pass++;
        drain("false_start");
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < BIT; k++) drive_cycle(1'b0);
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < BIT; k++) drive_cycle(b == 2);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        n_total++;
        if ({rdata, rx_ready, ferr, rx_busy} !== 11'h000)
            $display("FAIL reset_mid: got rdata=%h rdy=%0b ferr=%0b busy=%0b want 0", rdata, rx_ready, ferr, rx_busy);
        else n_pass++;
        last_good = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) drive_cycle(1'b1);
        send_frame(8'hC3, 1'b1, 1'b0);
        drain("reset_mid");
    endtask

    task automatic test_glitch;
        send_frame(8'h96, 1'b1, 1'b1);
        drain("glitch");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_framing;
        test_false_start;
        test_reset_mid;
        test_glitch;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
